// File: rtl/reaction_pkg.sv
// Shared types for the reaction timer: FSM states, result codes, LFSR step.
package reaction_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_GO,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RC_NONE    = 2'd0,
    RC_VALID   = 2'd1,
    RC_DQ      = 2'd2,
    RC_TIMEOUT = 2'd3
  } rcode_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, right-shifting
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/reaction_tick_gen.sv
// Millisecond prescaler: one-cycle tick every DIV clocks, restartable via clr.
module reaction_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reaction_multi_timer.sv
// Multi-player reaction-time core: random hold-off, GO lamp, per-player ms capture.
// Define REACTION_BEST_TIME_EN to keep a session best winner time in best_time.
module reaction_multi_timer
  import reaction_pkg::*;
#(
  parameter int          CLK_HZ       = 50_000_000,
  parameter int          PLAYERS      = 2,
  parameter int          TIME_W       = 14,
  parameter int          DELAY_MIN_MS = 1000,
  parameter int          DELAY_MASK   = 'h7FF,
  parameter int          TIMEOUT_MS   = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int         WIN_W        = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [PLAYERS-1:0]          btn,
  output logic                        go,
  output logic                        busy,
  output logic [TIME_W-1:0]           ms_count,
  output logic [2*PLAYERS-1:0]        result_code,
  output logic [TIME_W*PLAYERS-1:0]   result_time,
  output logic                        done,
  output logic [WIN_W-1:0]            winner,
  output logic                        winner_valid,
  output logic [TIME_W-1:0]           best_time
);

  localparam int HOLD_W = $clog2(DELAY_MIN_MS + DELAY_MASK + 2) + 1;

  state_t              state_q;
  state_t              state_d;
  logic [15:0]         lfsr;
  logic [HOLD_W-1:0]   hold;
  logic [TIME_W-1:0]   ms_q;
  logic [PLAYERS-1:0]  btn_prev;
  logic [PLAYERS-1:0]  rise;
  logic                tick;
  logic                round_start;
  logic                arm_last;
  logic                to_hit;
  logic                all_res;
  logic                enter_done;
  logic                done_q;
  logic                wv_q;
  logic                wv_d;
  logic [WIN_W-1:0]    win_q;
  logic [WIN_W-1:0]    win_d;
  logic [TIME_W-1:0]   best_t;

  assign round_start = start &&
                       (state_q == S_IDLE || state_q == S_DONE);
  assign arm_last    = (state_q == S_ARM) && tick &&
                       (hold == HOLD_W'(1));
  assign to_hit      = (state_q == S_GO) && tick &&
                       (ms_q == TIME_W'(TIMEOUT_MS - 1));
  assign rise        = btn & ~btn_prev;
  assign enter_done  = (state_d == S_DONE) && (state_q != S_DONE);

  reaction_tick_gen #(
    .DIV (CLK_HZ / 1000)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (round_start),
    .tick  (tick)
  );

  always_comb begin
    all_res = 1'b1;
    for (int i = 0; i < PLAYERS; i++) begin
      if (result_code[2*i +: 2] == RC_NONE) all_res = 1'b0;
    end
  end

  // Fastest VALID player; strict compare keeps the lowest index on ties
  always_comb begin
    win_d  = '0;
    wv_d   = 1'b0;
    best_t = '1;
    for (int i = 0; i < PLAYERS; i++) begin
      if (result_code[2*i +: 2] == RC_VALID &&
          (!wv_d || result_time[i*TIME_W +: TIME_W] < best_t)) begin
        wv_d   = 1'b1;
        best_t = result_time[i*TIME_W +: TIME_W];
        win_d  = WIN_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (round_start) state_d = S_ARM;
      S_ARM: begin
        if (all_res)       state_d = S_DONE;
        else if (arm_last) state_d = S_GO;
      end
      S_GO:   if (all_res) state_d = S_DONE;
      S_DONE: if (round_start) state_d = S_ARM;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr     <= LFSR_SEED;
      btn_prev <= '1;
      hold     <= '0;
      ms_q     <= '0;
      done_q   <= 1'b0;
      wv_q     <= 1'b0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr     <= lfsr_step(lfsr);
      btn_prev <= btn;
      done_q   <= enter_done;
      if (round_start) begin
        hold <= HOLD_W'(DELAY_MIN_MS) +
                HOLD_W'(lfsr & DELAY_MASK[15:0]);
      end else if (state_q == S_ARM && tick) begin
        hold <= hold - 1'b1;
      end
      if (round_start || arm_last) begin
        ms_q <= '0;
      end else if (state_q == S_GO && tick &&
                   ms_q != TIME_W'(TIMEOUT_MS)) begin
        ms_q <= ms_q + 1'b1;
      end
      if (round_start) begin
        wv_q  <= 1'b0;
        win_q <= '0;
      end else if (enter_done) begin
        wv_q  <= wv_d;
        win_q <= win_d;
      end
    end
  end

  for (genvar g = 0; g < PLAYERS; g++) begin : g_player
    rcode_t            code;
    logic [TIME_W-1:0] tm;

    always_ff @(posedge clk) begin
      if (reset || round_start) begin
        code <= RC_NONE;
        tm   <= '0;
      end else if (state_q == S_ARM && rise[g]) begin
        code <= RC_DQ;
      end else if (state_q == S_GO && code == RC_NONE) begin
        if (rise[g]) begin
          code <= RC_VALID;
          tm   <= ms_q;
        end else if (to_hit) begin
          code <= RC_TIMEOUT;
        end
      end
    end

    assign result_code[2*g +: 2]           = code;
    assign result_time[g*TIME_W +: TIME_W] = tm;
  end

`ifdef REACTION_BEST_TIME_EN
  logic [TIME_W-1:0] best_q;
  logic [TIME_W-1:0] win_time;

  assign win_time = result_time[win_q*TIME_W +: TIME_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      best_q <= '1;
    end else if (done_q && wv_q && win_time < best_q) begin
      best_q <= win_time;
    end
  end

  assign best_time = best_q;
`else
  assign best_time = '1;
`endif

  assign go           = (state_q == S_GO);
  assign busy         = (state_q == S_ARM) || (state_q == S_GO);
  assign ms_count     = ms_q;
  assign done         = done_q;
  assign winner       = win_q;
  assign winner_valid = wv_q;

endmodule

// File: doc/reaction_multi_timer.md
# reaction_multi_timer

Multi-player reaction-time core for the board-level reaction game. After a start request it waits a pseudo-random hold-off, raises a GO lamp, then timestamps each player's first button press in milliseconds. Players who press before GO are disqualified; players who never press time out. It sits between the debounced switch/button inputs and the HEX/LED display logic, replacing the single-player fixed-countdown counter chain.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency; the ms tick period is CLK_HZ/1000 cycles.
- `PLAYERS`, 2: number of button channels, 1..8.
- `TIME_W`, 14: width of the ms counters.
- `DELAY_MIN_MS`, 1000: minimum hold-off before GO.
- `DELAY_MASK`, 11'h7FF: random hold-off range mask (2^k-1). Hold-off is DELAY_MIN_MS + (lfsr & DELAY_MASK).
- `TIMEOUT_MS`, 9999: GO-phase limit. Must be < 2^TIME_W.
- `LFSR_SEED`, 16'hACE1: nonzero reset seed.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  round request pulse; honoured only in IDLE or DONE.
- `btn`  in  PLAYERS  synchronised, debounced buttons, active high.
- `go`  out  1  GO lamp.
- `busy`  out  1  high in ARM or GO.
- `ms_count`  out  TIME_W  live GO-phase elapsed ms.
- `result_code`  out  2*PLAYERS  per player: 0 NONE, 1 VALID, 2 DQ, 3 TIMEOUT.
- `result_time`  out  TIME_W*PLAYERS  per-player captured ms. Valid only when code is VALID; otherwise 0.
- `done`  out  1  one-cycle pulse on entry to DONE.
- `winner`  out  max(1,$clog2(PLAYERS))  index of the fastest VALID player.
- `winner_valid`  out  1  at least one VALID player in the last round.
- `best_time`  out  TIME_W  session best (see Configuration).

## Operation
States: IDLE, ARM, GO, DONE. Reset enters IDLE with all outputs 0, except `best_time`, which resets to all ones.
- IDLE -> ARM on `start`: clears the results, loads the hold-off counter, and clears the prescaler.
- ARM: the hold-off counter decrements on each ms tick. A rising edge of `btn[i]` sets code[i]=DQ. Enter GO on the tick where the counter equals 1. If every player is DQ, enter DONE immediately.
- GO: `go`=1. `ms_count` clears on entry and increments per tick. The first rising edge of `btn[i]` with code NONE captures `ms_count` and sets VALID. Enter DONE when no player is NONE, or on the tick where `ms_count` reaches TIMEOUT_MS. In the TIMEOUT_MS case, the remaining NONE players become TIMEOUT. `ms_count` stops at TIMEOUT_MS.
- DONE: results, `winner` and `winner_valid` are held. `start` begins a new round (DONE -> ARM directly).
- `start` in ARM/GO is ignored.
- Edge detection uses a registered `btn_prev`, which resets to all ones. A button held through reset or start does not register until it is released and pressed again.
- Simultaneous presses in one cycle capture identical times. On ties, `winner` is the lowest index.
- A press in the same cycle as the ARM->GO transition counts as DQ.
- The LFSR is a 16-bit Galois LFSR (taps 16,14,13,11). It advances every clock, including in IDLE.

## Timing
- `btn` edge at cycle n -> `result_code`/`result_time` update at n+1.
- `go` rises the cycle after the final hold-off tick. Hold-off is exact to ±1 clk.
- `done` is registered and asserts the cycle after the last result update. `winner`/`winner_valid` are valid in the same cycle as `done`.
- `reset` mid-round forces IDLE on the next edge. It clears results, the prescaler and `btn_prev`.

## Configuration
- `REACTION_BEST_TIME_EN` defined: `best_time` holds the minimum winner time across rounds. It updates in the `done` cycle when `winner_valid` is set and is cleared only by `reset`.
- Not defined: `best_time` is tied to all ones and no register is built.

## Structure
- Package `reaction_pkg`: state enum; result-code enum (NONE/VALID/DQ/TIMEOUT); the LFSR tap constant.
- Sub-module `reaction_tick_gen`: parametrised prescaler emitting a 1-cycle ms tick, with a synchronous `clr` input.
- The player loop is a generate over PLAYERS inside the core.

## Test plan
Sim parameters: CLK_HZ=50_000 (tick every 50 clk), PLAYERS=4, DELAY_MIN_MS=10, DELAY_MASK=3, TIMEOUT_MS=100.
- Start, no presses -> `go` rises after 10..13 ms. At 100 ms, all codes TIMEOUT, `done` pulses, `winner_valid`=0.
- Press p2 at GO+25 ms and p0 at GO+40 ms, with p1/p3 never pressing -> times 25/40, codes VALID, `winner`=2 after timeout at 100 ms.
- p1 presses during ARM, p3 presses at GO+7 ms -> p1 DQ with time 0. All others resolve, and `winner`=3.
- p0 and p3 press in the same clk at GO+12 ms -> both 12, `winner`=0. The other players then press, and `done` follows one cycle after the last press.
- Assert `reset` mid-GO -> IDLE next cycle, outputs zero. A button held across reset does not register after restart until it is released and pressed again.
- With `REACTION_BEST_TIME_EN`: rounds with winners at 30 then 50 ms -> `best_time`=30. Without the macro -> `best_time`=all ones.
